// File: rtl/gs_kernel_loader.sv
// Kernel-stream front end: decodes header words through gs_decode, latches scalar config,
// streams payload words to memories and launches kernels. Optional checks: GS_LOADER_LEN_CHECK_EN.
module gs_kernel_loader #(
   parameter int K_OP_WIDTH      = 4,
   parameter int K_CONTROL_WIDTH = 9,
   parameter int K_LEN_WIDTH     = 12,
   parameter int K_DATA_WIDTH    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [K_DATA_WIDTH-1:0]    k_data,
   input  logic                       k_valid,
   output logic                       k_ready,
   output logic [K_OP_WIDTH-1:0]      instr_k,
   input  logic [K_CONTROL_WIDTH-1:0] control_k,
   output logic [K_DATA_WIDTH-1:0]    grid_size,
   output logic [K_DATA_WIDTH-1:0]    block_size,
   output logic [K_DATA_WIDTH-1:0]    warp_count,
   output logic [K_DATA_WIDTH-1:0]    reg_count,
   output logic                       wr_en,
   output logic [3:0]                 wr_sel,
   output logic [K_LEN_WIDTH-1:0]     wr_addr,
   output logic [K_DATA_WIDTH-1:0]    wr_data,
   input  logic                       wr_ready,
   output logic                       kernel_start,
   output logic                       kernel_busy,
   input  logic                       kernel_done,
   output logic                       err
);

   typedef enum logic [1:0] {HDR, PAYLOAD, RUN} state_t;

   localparam logic [K_LEN_WIDTH-1:0] LEN_ONE = K_LEN_WIDTH'(1);

   state_t                     state, state_nx;
   logic [K_OP_WIDTH-1:0]      op_q;
   logic [K_LEN_WIDTH-1:0]     len_q;
   logic [K_LEN_WIDTH-1:0]     len_cnt;
   logic [K_CONTROL_WIDTH-1:0] ctrl_q;
   logic                       bad_q;
   logic                       start_q;
   logic                       hdr_hs;
   logic                       pay_hs;
   logic                       hdr_bad;
   logic                       scalar_hdr;
   logic                       mem_tgt;
   logic [K_OP_WIDTH-1:0]      hdr_op;
   logic [K_LEN_WIDTH-1:0]     hdr_len;

   assign hdr_op     = k_data[K_OP_WIDTH-1:0];
   assign hdr_len    = k_data[K_OP_WIDTH+K_LEN_WIDTH-1:K_OP_WIDTH];
   assign scalar_hdr = control_k[0] | control_k[1] | control_k[6] | control_k[7];
   assign mem_tgt    = |ctrl_q[5:2];

   assign instr_k      = (state == HDR) ? hdr_op : op_q;
   assign wr_addr      = len_cnt;
   assign wr_data      = k_data;
   assign kernel_start = start_q;
   assign kernel_busy  = (state == RUN);

`ifdef GS_LOADER_LEN_CHECK_EN
   logic err_q;

   assign hdr_bad = (control_k == '0)
                 || (scalar_hdr && (hdr_len != LEN_ONE))
                 || (control_k[8] && (hdr_len != '0));
   assign err     = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_q <= 1'b0;
      else if (hdr_hs && hdr_bad)
         err_q <= 1'b1;
   end
`else
   assign hdr_bad = 1'b0;
   assign err     = 1'b0;
`endif

   // Next state and handshakes; a flagged header still drains its payload but writes nothing
   always_comb begin
      state_nx = state;
      k_ready  = 1'b0;
      wr_en    = 1'b0;
      wr_sel   = 4'b0000;
      hdr_hs   = 1'b0;
      pay_hs   = 1'b0;
      case (state)
         HDR: begin
            k_ready = 1'b1;
            hdr_hs  = k_valid;
            if (k_valid) begin
               if (control_k[8] && !hdr_bad)
                  state_nx = RUN;
               else if (hdr_len == '0)
                  state_nx = HDR;
               else
                  state_nx = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (mem_tgt && !bad_q) begin
               k_ready = wr_ready;
               wr_sel  = ctrl_q[5:2];
               wr_en   = k_valid & wr_ready;
            end else begin
               k_ready = 1'b1;
            end
            pay_hs = k_valid & k_ready;
            if (pay_hs && (len_cnt == len_q - LEN_ONE))
               state_nx = HDR;
         end
         RUN: begin
            if (kernel_done)
               state_nx = HDR;
         end
         default: state_nx = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= HDR;
      else
         state <= state_nx;
   end

   // Header latches, payload counter and the first-word scalar loads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         len_q      <= '0;
         ctrl_q     <= '0;
         bad_q      <= 1'b0;
         len_cnt    <= '0;
         start_q    <= 1'b0;
         grid_size  <= '0;
         block_size <= '0;
         warp_count <= '0;
         reg_count  <= '0;
      end else begin
         start_q <= hdr_hs && control_k[8] && !hdr_bad;
         if (hdr_hs) begin
            op_q    <= hdr_op;
            len_q   <= hdr_len;
            ctrl_q  <= control_k;
            bad_q   <= hdr_bad;
            len_cnt <= '0;
         end
         if (pay_hs) begin
            len_cnt <= len_cnt + LEN_ONE;
            if ((len_cnt == '0) && !bad_q) begin
               if (ctrl_q[0]) grid_size  <= k_data;
               if (ctrl_q[1]) block_size <= k_data;
               if (ctrl_q[6]) warp_count <= k_data;
               if (ctrl_q[7]) reg_count  <= k_data;
            end
         end
      end
   end

endmodule
